// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment driver with a sequential
// double-dabble BCD converter, hex pass-through and anti-ghost blanking.
module seg7_scan_driver #(
    parameter int DIGITS    = 4,
    parameter int DATA_W    = 16,
    parameter int SCAN_CYC  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              hex_mode,
    input  logic              lzb,
    output logic              ovf,
    output logic [DIGITS-1:0] cs,
    output logic [7:0]        dx
);

    localparam int BW = 4 * (DIGITS + 1);
    localparam int XW = DATA_W + 4 * DIGITS;
    localparam int CW = $clog2(DATA_W + 1);
    localparam int DW = $clog2(SCAN_CYC + 1);
    localparam int IW = $clog2(DIGITS);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic              xfer;
    logic [DATA_W-1:0] data_q;
    logic              hex_q;
    logic              lzb_q;
    logic [BW-1:0]     bcd_q;
    logic [BW-1:0]     adj;
    logic [CW-1:0]     iter;
    logic              spill_q;
    logic [XW-1:0]     ext;
    logic              hex_ovf;

    logic [3:0]        dig_q [DIGITS];
    logic              lzb_d;
    logic              ovf_q;
    logic [7:0]        code  [DIGITS];
    logic [DIGITS-1:0] blank;
    logic              zero_run;

    logic [DW-1:0]     dwell;
    logic [IW-1:0]     idx;
    logic [DIGITS-1:0] cs_q;
    logic [7:0]        dx_q;

    function automatic logic [7:0] seg7(input logic [3:0] n);
        logic [7:0] s;
        unique case (n)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    assign in_ready = (state == IDLE);
    assign xfer     = in_valid & in_ready;
    assign ovf      = ovf_q;
    assign cs       = cs_q;
    assign dx       = dx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (xfer) state_nxt = CONV;
            CONV: if (hex_q || iter == CW'(DATA_W - 1)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Add-3 correction on every nibble ahead of the shift
    always_comb begin
        adj = bcd_q;
        for (int k = 0; k < DIGITS + 1; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
    end

    assign ext     = XW'(data_q);
    assign hex_ovf = |ext[XW-1:4*DIGITS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            hex_q   <= 1'b0;
            lzb_q   <= 1'b0;
            bcd_q   <= '0;
            iter    <= '0;
            spill_q <= 1'b0;
        end else if (state == IDLE) begin
            if (xfer) begin
                data_q  <= in_data;
                hex_q   <= hex_mode;
                lzb_q   <= lzb;
                bcd_q   <= '0;
                iter    <= '0;
                spill_q <= 1'b0;
            end
        end else if (state == CONV) begin
            if (hex_q) begin
                bcd_q   <= BW'(ext[4*DIGITS-1:0]);
                spill_q <= hex_ovf;
            end else begin
                // A carry out of the guard nibble means the value is far too big
                bcd_q   <= {adj[BW-2:0], data_q[DATA_W-1]};
                spill_q <= spill_q | adj[BW-1];
                data_q  <= data_q << 1;
                iter    <= iter + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) dig_q[i] <= 4'd0;
            lzb_d <= 1'b0;
            ovf_q <= 1'b0;
        end else if (state == DONE) begin
            for (int i = 0; i < DIGITS; i++) dig_q[i] <= bcd_q[4*i +: 4];
            lzb_d <= lzb_q;
            ovf_q <= spill_q | (|bcd_q[BW-1 -: 4]);
        end
    end

    always_comb begin
        zero_run = 1'b1;
        blank    = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run && (dig_q[i] == 4'd0);
            blank[i] = zero_run && lzb_d;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (ovf_q)         code[i] = 8'hBF;
            else if (blank[i]) code[i] = 8'hFF;
            else               code[i] = seg7(dig_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell <= '0;
            idx   <= '0;
            cs_q  <= '1;
            dx_q  <= 8'hFF;
        end else begin
            if (dwell == DW'(SCAN_CYC - 1)) begin
                dwell <= '0;
                idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                dwell <= dwell + 1'b1;
            end
            // Blank window lets the previous digit's driver turn off first
            if (dwell < DW'(BLANK_CYC)) begin
                cs_q <= '1;
                dx_q <= 8'hFF;
            end else begin
                cs_q <= ~(DIGITS'(1) << idx);
                dx_q <= code[idx];
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: scan timing, decimal/hex
// conversion, blanking, overflow, busy handling and async reset.
module tb_seg7_scan_driver;

    localparam int DIGITS    = 4;
    localparam int DATA_W    = 16;
    localparam int SCAN_CYC  = 8;
    localparam int BLANK_CYC = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              hex_mode;
    logic              lzb;
    logic              ovf;
    logic [DIGITS-1:0] cs;
    logic [7:0]        dx;

    int checks = 0;
    int errors = 0;
    int lat;

    seg7_scan_driver #(
        .DIGITS   (DIGITS),
        .DATA_W   (DATA_W),
        .SCAN_CYC (SCAN_CYC),
        .BLANK_CYC(BLANK_CYC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .hex_mode(hex_mode),
        .lzb     (lzb),
        .ovf     (ovf),
        .cs      (cs),
        .dx      (dx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic hx, input logic lz);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_data  = d;
        hex_mode = hx;
        lzb      = lz;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic capture(input string tag, input logic [7:0] e3, input logic [7:0] e2,
                           input logic [7:0] e1, input logic [7:0] e0);
        logic [7:0] got [4];
        logic [7:0] exp [4];
        int lowc [4];
        bit blank_ok = 1'b1;
        exp[0] = e0;
        exp[1] = e1;
        exp[2] = e2;
        exp[3] = e3;
        for (int i = 0; i < 4; i++) begin
            got[i]  = 8'h00;
            lowc[i] = 0;
        end
        for (int c = 0; c < 4 * SCAN_CYC; c++) begin
            @(negedge clk);
            case (cs)
                4'b1110: begin got[0] = dx; lowc[0]++; end
                4'b1101: begin got[1] = dx; lowc[1]++; end
                4'b1011: begin got[2] = dx; lowc[2]++; end
                4'b0111: begin got[3] = dx; lowc[3]++; end
                4'b1111: if (dx !== 8'hFF) blank_ok = 1'b0;
                default: blank_ok = 1'b0;
            endcase
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_dx%0d", tag, i), {24'd0, got[i]}, {24'd0, exp[i]});
            chk($sformatf("%s_low%0d", tag, i), lowc[i], SCAN_CYC - BLANK_CYC);
        end
        chk({tag, "_blank"}, {31'd0, blank_ok}, 32'd1);
    endtask

    initial begin
        rst_n    = 1'b1;
        in_data  = '0;
        in_valid = 1'b0;
        hex_mode = 1'b0;
        lzb      = 1'b0;
        #2 rst_n = 1'b0;
        #30;
        chk("rst_cs", {28'd0, cs}, 32'hF);
        chk("rst_dx", {24'd0, dx}, 32'hFF);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        capture("zero", 8'hC0, 8'hC0, 8'hC0, 8'hC0);

        send(16'd1234, 1'b0, 1'b0);
        chk("busy_1234", {31'd0, in_ready}, 32'd0);
        wait_idle(lat);
        chk("lat_1234", lat, DATA_W + 1);
        chk("ovf_1234", {31'd0, ovf}, 32'd0);
        capture("d1234", 8'hF9, 8'hA4, 8'hB0, 8'h99);

        send(16'd42, 1'b0, 1'b1);
        wait_idle(lat);
        capture("lzb42", 8'hFF, 8'hFF, 8'h99, 8'hA4);

        send(16'd0, 1'b0, 1'b1);
        wait_idle(lat);
        capture("lzb0", 8'hFF, 8'hFF, 8'hFF, 8'hC0);

        send(16'hBEEF, 1'b1, 1'b0);
        wait_idle(lat);
        chk("lat_hex", lat, 2);
        chk("ovf_hex", {31'd0, ovf}, 32'd0);
        capture("hBEEF", 8'h83, 8'h86, 8'h86, 8'h8E);

        send(16'd9999, 1'b0, 1'b0);
        wait_idle(lat);
        chk("ovf_9999", {31'd0, ovf}, 32'd0);
        capture("d9999", 8'h90, 8'h90, 8'h90, 8'h90);

        send(16'd10000, 1'b0, 1'b0);
        wait_idle(lat);
        chk("ovf_10000", {31'd0, ovf}, 32'd1);

        send(16'd12345, 1'b0, 1'b0);
        wait_idle(lat);
        chk("ovf_12345", {31'd0, ovf}, 32'd1);
        capture("d12345", 8'hBF, 8'hBF, 8'hBF, 8'hBF);

        send(16'd7, 1'b0, 1'b0);
        chk("ovf_hold", {31'd0, ovf}, 32'd1);
        wait_idle(lat);
        chk("ovf_7", {31'd0, ovf}, 32'd0);
        capture("d7", 8'hC0, 8'hC0, 8'hC0, 8'hF8);

        send(16'd5, 1'b0, 1'b1);
        @(negedge clk);
        in_data  = 16'd9;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("busy_5", {31'd0, in_ready}, 32'd0);
        wait_idle(lat);
        repeat (4) @(negedge clk);
        chk("no_requeue", {31'd0, in_ready}, 32'd1);
        capture("d5", 8'hFF, 8'hFF, 8'hFF, 8'h92);

        send(16'd1234, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cs", {28'd0, cs}, 32'hF);
        chk("arst_dx", {24'd0, dx}, 32'hFF);
        chk("arst_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        capture("post_rst", 8'hC0, 8'hC0, 8'hC0, 8'hC0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
